// File: rtl/divider_pkg.sv
// Shared types and sizing for the iterative restoring divider.
package divider_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int CNT_W     = $clog2(DIV_WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    FIX,
    DONE
  } div_state_t;

endpackage

// File: rtl/divider_if.sv
// Request/result bundle between the execute-stage controller and the divider.
interface divider_if #(parameter int WIDTH = divider_pkg::DIV_WIDTH);

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             en;
  logic             dz;

  modport master (output start, is_signed, a, b, input q, r, en, dz);
  modport slave  (input start, is_signed, a, b, output q, r, en, dz);

endinterface

// File: rtl/divider_step.sv
// One restoring-division iteration on unsigned magnitudes.
module div_step
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_nx,
  output logic [WIDTH-1:0] quo_nx
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem < divisor holds between steps, so the difference always fits WIDTH+1 signed bits
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {1'b0, divisor};
    if (!trial[WIDTH]) begin
      rem_nx = trial[WIDTH-1:0];
      quo_nx = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_nx = shifted[WIDTH-1:0];
      quo_nx = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/divider.sv
// Iterative divider: one quotient bit per clock, sign fix-up, result held with en.
//
//   state | meaning
//   IDLE  | reset state, waiting for start
//   DIV   | WIDTH restoring iterations on magnitudes
//   FIX   | sign correction, result registers loaded
//   DONE  | result held with en=1, new start accepted
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic     clk,
  input  logic     reset,
  divider_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_t       state_q, state_d;
  logic             accept;
  logic [CNT_W-1:0] count;
  logic             sa, sb, zero;
  logic [WIDTH-1:0] mag_b, a_orig;
  logic [WIDTH-1:0] rem, quo;
  logic [WIDTH-1:0] rem_nx, quo_nx;
  logic [WIDTH-1:0] q_r, r_r;
  logic             en_r, dz_r;
  logic             sa_in, sb_in;

  assign sa_in = bus.is_signed & bus.a[WIDTH-1];
  assign sb_in = bus.is_signed & bus.b[WIDTH-1];

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem),
    .quo     (quo),
    .divisor (mag_b),
    .rem_nx  (rem_nx),
    .quo_nx  (quo_nx)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = DIV;
        end
      end
      DIV:     if (count == LAST_CNT) state_d = FIX;
      FIX:     state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      zero   <= 1'b0;
      mag_b  <= '0;
      a_orig <= '0;
      rem    <= '0;
      quo    <= '0;
      q_r    <= '0;
      r_r    <= '0;
      en_r   <= 1'b0;
      dz_r   <= 1'b0;
    end else if (accept) begin
      sa     <= sa_in;
      sb     <= sb_in;
      zero   <= (bus.b == '0);
      mag_b  <= sb_in ? -bus.b : bus.b;
      quo    <= sa_in ? -bus.a : bus.a;
      a_orig <= bus.a;
      rem    <= '0;
      count  <= '0;
      en_r   <= 1'b0;
    end else if (state_q == DIV) begin
      rem   <= rem_nx;
      quo   <= quo_nx;
      count <= count + CNT_W'(1);
    end else if (state_q == FIX) begin
      // a zero divisor still runs the full iteration count; only the result is replaced
      if (zero) begin
        q_r  <= '1;
        r_r  <= a_orig;
        dz_r <= 1'b1;
      end else begin
        q_r  <= (sa ^ sb) ? -quo : quo;
        r_r  <= sa ? -rem : rem;
        dz_r <= 1'b0;
      end
      en_r <= 1'b1;
    end
  end

  assign bus.q  = q_r;
  assign bus.r  = r_r;
  assign bus.en = en_r;
  assign bus.dz = dz_r;

endmodule

// File: doc/divider.md
# divider

Iterative 32-bit integer divider, the inverse companion of the sequential `multiplier`, sharing its start/en handshake and `is_signed` convention.
- Accepts dividend `a` and divisor `b` on `start`.
- Computes one restoring-division quotient bit per clock.
- Presents quotient `q` and remainder `r` with `en` held high until the next operation.
- Sits beside `multiplier` in the execute stage; the same controller drives both.

## Interface
- `WIDTH`, default 32: operand, quotient and remainder width.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  request; sampled only in IDLE or DONE.
- `is_signed`  input  1  1 = two's-complement operands, 0 = unsigned; sampled with `start`.
- `a`  input  WIDTH  dividend; sampled with `start`.
- `b`  input  WIDTH  divisor; sampled with `start`.
- `q`  output  WIDTH  quotient, registered; reset 0.
- `r`  output  WIDTH  remainder, registered; reset 0.
- `en`  output  1  result valid, level; reset 0.
- `dz`  output  1  divide-by-zero flag, valid while `en`=1; reset 0.

## Operation
- States:
  - IDLE: reset state.
  - DIV: WIDTH iterations.
  - FIX: sign correction and result register.
  - DONE: result held.
- Transitions:
  - IDLE/DONE with `start`=1 → DIV.
  - DIV with count = WIDTH−1 → FIX.
  - FIX → DONE unconditionally.
  - DONE with `start`=0 → stays in DONE.
- Accept edge (`start`=1 in IDLE/DONE):
  - Latch `is_signed`.
  - Latch sign bits sa = `is_signed`&a[MSB] and sb = `is_signed`&b[MSB].
  - Latch magnitudes |a|, |b|.
  - Latch zero flag (b == 0).
  - Clear partial remainder, clear count, drive `en`=0.
- DIV edge (one restoring step):
  - {rem, quo} shifted left by 1.
  - trial = rem − |b| computed at WIDTH+1 bits.
  - trial ≥ 0: rem = trial, quo LSB = 1.
  - trial < 0: rem unchanged, quo LSB = 0.
  - count increments.
- FIX edge, normal case:
  - `q` = (sa^sb) ? −quo : quo.
  - `r` = sa ? −rem : rem; the remainder takes the dividend's sign, and the quotient truncates toward zero.
  - `dz`=0, `en`=1.
- FIX edge, divide by zero:
  - `q` = all ones, `r` = original `a`, `dz`=1, `en`=1.
  - Same latency as the normal case; the iterations still run and their result is discarded.
- Signed overflow (−2^(WIDTH−1) / −1): `q` = 0x80000000, `r` = 0. The magnitude path yields this naturally; no special case is needed.
- `start` while in DIV or FIX is ignored; the operation in flight is unaffected.
- `start` held high continuously: a new operation is accepted on each entry to DONE, so `en` is high for exactly one cycle between back-to-back operations.
- `reset`=1 at any edge, including mid-DIV:
  - State → IDLE.
  - `q`, `r`, `en`, `dz`, count and internal registers → 0.
  - A `start` asserted at the same edge is ignored.

## Timing
- Accept edge E0; DIV iterations occupy E1..E32; FIX at E33.
- `en`=1 from E33 until the next accept edge or reset: latency 33 cycles from accept to `en`.
- `q`, `r` and `dz` are stable and unchanged throughout DONE.
- At an accept from DONE, `en` falls at that same edge; `q`/`r` keep their old values until the next FIX.
- No combinational path from any input to any output.

## Structure
- Package `divider_pkg`:
  - State enum `div_state_t` {IDLE, DIV, FIX, DONE}.
  - `DIV_WIDTH` = 32.
  - Count width `CNT_W` = $clog2(DIV_WIDTH)+1.
- Sub-module `div_step`: combinational single restoring iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
- The top level holds the FSM, counter, sign/zero latches and the FIX negation.

## Test plan
- Unsigned: a=100, b=7, is_signed=0 → after 33 cycles `en`=1, q=14, r=2, dz=0.
- Signed (both operand pairs pulse start from IDLE):
  - a=0xFFFFFFF9 (−7), b=2 → q=0xFFFFFFFD (−3), r=0xFFFFFFFF (−1).
  - a=0xFFFFFFFF, b=0xFFFFFFFF → is_signed=1 gives q=1, r=0; is_signed=0 gives q=1, r=0.
- Boundaries:
  - a=0x80000000, b=0xFFFFFFFF, signed → q=0x80000000, r=0.
  - a=0x12345678, b=0 → q=0xFFFFFFFF, r=0x12345678, dz=1.
- Start while busy: `start` pulsed at cycle 10 of an operation with new operands → ignored; the result matches the original operands at cycle 33.
- Reset mid-operation: `reset` at cycle 15 → next edge shows IDLE with `en`=q=r=dz=0; a fresh start then completes correctly in 33 cycles.
- Back-to-back: `start` held high with a=0xFFFFFFFF, b=3 unsigned → `en` high for one cycle every 34 cycles, q=0x55555555, r=0.
